// File: rtl/mul_pkg.sv
// Shared definitions for the MUL peripheral and its Avalon-MM master.
// Word addresses of the slave registers and the master FSM states.
package mul_pkg;

  localparam logic [1:0] MUL_ADDR_A = 2'b00;
  localparam logic [1:0] MUL_ADDR_B = 2'b01;
  localparam logic [1:0] MUL_ADDR_R = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_RD,
    ST_WAIT,
    ST_RESP
  } mul_state_e;

endpackage

// File: rtl/mul_avalon_master.sv
// Avalon-MM master: writes an operand pair to the MUL slave, reads back
// the product and returns it on a valid/ready response port.
module mul_avalon_master
  import mul_pkg::*;
#(
  parameter int         READ_LATENCY = 1,
  parameter int         TIMEOUT      = 255,
  parameter logic [1:0] ADDR_A       = MUL_ADDR_A,
  parameter logic [1:0] ADDR_B       = MUL_ADDR_B,
  parameter logic [1:0] ADDR_R       = MUL_ADDR_R
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic        avm_chipselect,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  mul_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [15:0] stall_q, stall_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [1:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        cs_q, cs_d;
  logic [31:0] wdata_q, wdata_d;
  logic        abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      stall_q     <= '0;
      lat_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      cs_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      read_q      <= read_d;
      cs_q        <= cs_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    stall_d    = stall_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    abort      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          stall_d = '0;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A, ST_WR_B, ST_RD: begin
        if (!avm_waitrequest) begin
          stall_d = '0;
          unique case (state_q)
            ST_WR_A: state_d = ST_WR_B;
            ST_WR_B: state_d = ST_RD;
            default: begin
              lat_d   = LAT_INIT;
              state_d = ST_WAIT;
            end
          endcase
        end else if (stall_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (lat_q == 3'd0) begin
          rsp_data_d = avm_readdata;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled transfer gives up and reports an empty, flagged result.
    if (abort) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b1;
      state_d    = ST_RESP;
    end
  end

  // Outputs are decoded from the next state so every strobe is a flop.
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    addr_d      = '0;
    write_d     = 1'b0;
    read_d      = 1'b0;
    wdata_d     = '0;
    unique case (1'b1)
      (state_d == ST_IDLE): cmd_ready_d = 1'b1;
      (state_d == ST_RESP): rsp_valid_d = 1'b1;
      (state_d == ST_WR_A): begin
        addr_d  = ADDR_A;
        write_d = 1'b1;
        wdata_d = a_d;
      end
      (state_d == ST_WR_B): begin
        addr_d  = ADDR_B;
        write_d = 1'b1;
        wdata_d = b_d;
      end
      (state_d == ST_RD): begin
        addr_d = ADDR_R;
        read_d = 1'b1;
      end
      default: ;
    endcase
    cs_d = write_d | read_d;
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_chipselect = cs_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_mul_avalon_master.sv
// Directed bench for mul_avalon_master with a behavioural MUL slave
// that can stall writes to operand B or hang on the result read.
module tb_mul_avalon_master;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic        avm_chipselect;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  // Slave model controls
  int   wrb_stall_cfg = 0;
  logic stuck_rd = 1'b0;
  int   wrb_cnt = 0;
  int   bus_cnt = 0;
  logic [31:0] sl_a, sl_b;

  always #5 clk = ~clk;

  mul_avalon_master #(
    .READ_LATENCY(1),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_read(avm_read),
    .avm_chipselect(avm_chipselect),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  assign avm_waitrequest =
    (avm_write && avm_address == MUL_ADDR_B && wrb_cnt < wrb_stall_cfg) ||
    (stuck_rd && avm_read);

  always @(posedge clk) begin
    if (!(avm_write && avm_address == MUL_ADDR_B)) wrb_cnt <= 0;
    else if (avm_waitrequest) wrb_cnt <= wrb_cnt + 1;
    if (avm_chipselect) bus_cnt <= bus_cnt + 1;
  end

  always @(posedge clk) begin
    if (reset) begin
      sl_a <= '0;
      sl_b <= '0;
      avm_readdata <= '0;
    end else if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write && avm_address == MUL_ADDR_A) sl_a <= avm_writedata;
      if (avm_write && avm_address == MUL_ADDR_B) sl_b <= avm_writedata;
      if (avm_read && avm_address == MUL_ADDR_R) avm_readdata <= sl_a * sl_b;
    end
  end

  // Returns one cycle after the accepting edge (cycle 1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b want 0", avm_read); end
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", avm_write); end
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", avm_chipselect); end
    checks++; if (avm_address !== 2'b00) begin errors++; $display("FAIL rst_addr: got %h want 0", avm_address); end
    checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", avm_writedata); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_basic();
    int cyc;
    issue(32'd7, 32'hFFFF_FFFD);
    checks++; if (avm_write !== 1'b1 || avm_address !== 2'b00 || avm_writedata !== 32'd7) begin
      errors++; $display("FAIL basic_wr_a: w=%b addr=%h d=%h want 1/0/7", avm_write, avm_address, avm_writedata); end
    wait_rsp(1, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", cyc); end
    checks++; if (rsp_data !== 32'hFFFF_FFEB) begin errors++; $display("FAIL basic_data: got %h want ffffffeb", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", rsp_err); end
    @(posedge clk); #1;
    checks++; if (sl_a !== 32'd7) begin errors++; $display("FAIL basic_bus_a: got %h want 7", sl_a); end
    checks++; if (sl_b !== 32'hFFFF_FFFD) begin errors++; $display("FAIL basic_bus_b: got %h want fffffffd", sl_b); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b want 0", rsp_valid); end
  endtask

  task automatic test_overflow();
    int cyc;
    issue(32'h0001_0000, 32'h0001_0000);
    wait_rsp(1, cyc);
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL ovf_wrap0: got %h want 0", rsp_data); end
    @(posedge clk); #1;
    issue(32'h7FFF_FFFF, 32'd2);
    wait_rsp(1, cyc);
    checks++; if (rsp_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ovf_max: got %h want fffffffe", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_waitrequest();
    int cyc;
    wrb_stall_cfg = 3;
    issue(32'd6, 32'd7);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 2'b01 || avm_writedata !== 32'd7) begin
        errors++;
        $display("FAIL wr_hold_c%0d: w=%b addr=%h d=%h want 1/1/7", k, avm_write, avm_address, avm_writedata);
      end
    end
    @(posedge clk); #1;
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL wr_then_read: got %b want 1", avm_read); end
    wait_rsp(6, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL wr_latency: got %0d want 8", cyc); end
    checks++; if (rsp_data !== 32'd42) begin errors++; $display("FAIL wr_data: got %h want 2a", rsp_data); end
    wrb_stall_cfg = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cyc;
    stuck_rd = 1'b1;
    issue(32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL to_read_c6: got %b want 1", avm_read); end
    @(posedge clk); #1;
    checks++; if (avm_read !== 1'b0 || avm_chipselect !== 1'b0) begin
      errors++; $display("FAIL to_drop: read=%b cs=%b want 0/0", avm_read, avm_chipselect); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", rsp_err); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL to_data: got %h want 0", rsp_data); end
    stuck_rd = 1'b0;
    @(posedge clk); #1;
    issue(32'd3, 32'd4);
    wait_rsp(1, cyc);
    checks++; if (rsp_data !== 32'd12 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL to_recover: data=%h err=%b want c/0", rsp_data, rsp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bus0;
    rsp_ready = 1'b0;
    issue(32'd9, 32'd9);
    wait_rsp(1, cyc);
    bus0 = bus_cnt;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd81 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: v=%b d=%h e=%b rdy=%b want 1/51/0/0", k, rsp_valid, rsp_data, rsp_err, cmd_ready);
      end
      @(posedge clk); #1;
    end
    checks++; if (bus_cnt !== bus0) begin errors++; $display("FAIL bp_bus_idle: got %0d want %0d", bus_cnt, bus0); end
    rsp_ready = 1'b1;
    cmd_a = 32'd2;
    cmd_b = 32'd3;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || avm_write !== 1'b0) begin
      errors++; $display("FAIL bp_release: v=%b rdy=%b w=%b want 0/1/0", rsp_valid, cmd_ready, avm_write); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0 || avm_write !== 1'b1 || avm_writedata !== 32'd2) begin
      errors++; $display("FAIL bp_accept: rdy=%b w=%b d=%h want 0/1/2", cmd_ready, avm_write, avm_writedata); end
    wait_rsp(1, cyc);
    checks++; if (rsp_data !== 32'd6) begin errors++; $display("FAIL bp_next_data: got %h want 6", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic seen;
    issue(32'd4, 32'd5);
    @(posedge clk); #1;
    checks++; if (avm_address !== 2'b01 || avm_write !== 1'b1) begin
      errors++; $display("FAIL mid_in_wr_b: addr=%h w=%b want 1/1", avm_address, avm_write); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
        avm_read !== 1'b0 || avm_write !== 1'b0 || avm_chipselect !== 1'b0 ||
        avm_address !== 2'b00 || avm_writedata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: rdy=%b v=%b d=%h e=%b r=%b w=%b cs=%b a=%h wd=%h want all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, avm_read, avm_write, avm_chipselect,
               avm_address, avm_writedata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b want 1", cmd_ready); end
    seen = 1'b0;
    repeat (8) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b want 0", seen); end
    issue(32'hFFFF_FFFE, 32'd2);
    wait_rsp(1, cyc);
    checks++; if (rsp_data !== 32'hFFFF_FFFC || cyc !== 5) begin
      errors++; $display("FAIL mid_after: data=%h lat=%0d want fffffffc/5", rsp_data, cyc); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_waitrequest();
    test_timeout();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_avalon_master.md
Name: mul_avalon_master

Overview:
Avalon-MM master that drives the multiplier peripheral's slave port on behalf of a local requester. It accepts an operand pair on a valid/ready command port, writes operand A and operand B to the slave, issues a result read, and captures the returned data. The result is presented on a valid/ready response port. It sits between a hardware accelerator pipeline and the MUL slave, replacing CPU-driven register pokes.

Parameters:
READ_LATENCY, 1, cycles from accepted read to valid readdata (legal 1..4); the MUL slave registers readdata, so its value is 1
TIMEOUT, 255, max consecutive waitrequest-high cycles before a transfer aborts (legal 1..65535)
ADDR_A, 2'b00, slave word address of operand A
ADDR_B, 2'b01, slave word address of operand B
ADDR_R, 2'b10, address used for the result read

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  operand pair valid
cmd_ready  out  1  block can accept a command
cmd_a  in  32  signed operand A
cmd_b  in  32  signed operand B
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  signed 32-bit product returned by the slave
rsp_err  out  1  transfer aborted by timeout; rsp_data is 0
avm_address  out  2  Avalon address
avm_write  out  1  write strobe
avm_read  out  1  read strobe
avm_chipselect  out  1  asserted with every read/write
avm_writedata  out  32  write data
avm_readdata  in  32  read data from slave
avm_waitrequest  in  1  slave stall; tie 0 for the MUL slave

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, avm_read=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0. The FSM returns to IDLE. cmd_ready rises one cycle after reset is released.
- Reset asserted mid-transaction aborts it on that edge. No response is produced and all strobes drop the next cycle.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_a and cmd_b into a_q and b_q, then go to WR_A.
  - WR_A: avm_write=1, chipselect=1, address=ADDR_A, writedata=a_q. On !waitrequest go to WR_B.
  - WR_B: same as WR_A with ADDR_B and b_q. On !waitrequest go to RD.
  - RD: avm_read=1, chipselect=1, address=ADDR_R. On !waitrequest go to WAIT, loading the latency counter with READ_LATENCY-1.
  - WAIT: no strobes. When the counter is 0, capture avm_readdata into rsp_data with rsp_err=0 and go to RESP. Otherwise decrement.
  - RESP: rsp_valid=1, with rsp_data and rsp_err held stable. On rsp_ready go to IDLE.
- Strobes are registered outputs. Address, data and strobe are held constant while waitrequest=1.
- Each state transition takes exactly one cycle.
- Latency with waitrequest=0 and READ_LATENCY=1: cmd accepted at edge 0, write A at cycle 1, write B at cycle 2, read at cycle 3, capture at edge 4, rsp_valid in cycle 5. That is 5 cycles from command accept to rsp_valid.
- Timeout: a 16-bit stall counter clears on entry to WR_A, WR_B and RD, and increments each cycle waitrequest=1 in those states. When it reaches TIMEOUT, the strobes drop, rsp_err=1 and rsp_data=0 are set, and the FSM goes to RESP.
- cmd_ready is 1 only in IDLE. The back-to-back cmd_valid rule follows from this:
  - In the RESP cycle where rsp_ready=1, the next command is not accepted.
  - It is accepted no earlier than the following cycle.
- Arithmetic is performed only by the slave. The block passes the low 32 bits through unmodified; no sign extension or saturation.

Decomposition:
- Shared package mul_pkg: address constants (MUL_ADDR_A, MUL_ADDR_B, MUL_ADDR_R) and the FSM state enum.
- The slave also uses the address constants from mul_pkg.
- No sub-module is needed. The stall counter and latency counter stay inline.

Test Plan:
- Basic: cmd_a=7, cmd_b=-3 against the real MUL slave, rsp_ready=1 -> bus writes 7 at address 0 and 0xFFFFFFFD at address 1, then a read. rsp_data=0xFFFFFFEB, rsp_err=0, rsp_valid exactly 5 cycles after cmd accept.
- Overflow wrap: 0x00010000 * 0x00010000 -> rsp_data=0x00000000; 0x7FFFFFFF * 2 -> 0xFFFFFFFE.
- Waitrequest: model slave stalls 3 cycles on WR_B -> address, writedata and avm_write are stable for 4 cycles. The result is still correct and latency grows by 3.
- Timeout: TIMEOUT=4, waitrequest stuck at 1 during RD -> read drops after 4 stall cycles; rsp_valid=1, rsp_err=1, rsp_data=0. The next command completes normally.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_err are stable, cmd_ready=0 and no bus activity. A command offered at the release cycle is accepted one cycle later.
- Reset mid-op: assert reset while in WR_B -> all outputs are at reset values next cycle and no response is produced. cmd_ready=1 one cycle after reset is released.
